// File: rtl/audio_voice_if.sv
// Register-write bus and voice outputs between the CPU side and the voice scheduler.
interface audio_voice_if #(
    parameter int NUM_CH = 4
);
    localparam int AW = $clog2(NUM_CH) + 2;

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [7:0]             wr_data;
    logic [NUM_CH*16-1:0]   freq_out;
    logic [NUM_CH*4-1:0]    vol_out;
    logic [NUM_CH-1:0]      active;
    logic                   frame_tick;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  freq_out, vol_out, active, frame_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output freq_out, vol_out, active, frame_tick
    );
endinterface

// File: rtl/audio_voice_scheduler.sv
// Per-voice frequency/envelope registers with a frame-tick driven duration and
// linear volume-decay envelope for a bank of square-wave channels.
module audio_voice_lane (
    input  logic        clk_1mhz,
    input  logic        rst,
    input  logic        tick,
    input  logic        wr_sel,
    input  logic [1:0]  wr_reg,
    input  logic [7:0]  wr_data,
    output logic [15:0] freq,
    output logic [3:0]  vol,
    output logic        active
);
    logic [7:0] shadow_lo, dur_cnt;
    logic [3:0] vol_init, decay_rate, vol_cur, decay_cnt;

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            freq       <= '0;
            shadow_lo  <= '0;
            vol_init   <= '0;
            decay_rate <= '0;
            vol_cur    <= '0;
            decay_cnt  <= '0;
            dur_cnt    <= '0;
            active     <= 1'b0;
        end else begin
            if (wr_sel) begin
                case (wr_reg)
                    2'd0:    shadow_lo <= wr_data;
                    2'd1:    freq <= {wr_data, shadow_lo};
                    2'd2:    {vol_init, decay_rate} <= wr_data;
                    default: ;
                endcase
            end

            // KEYON owns the voice on its edge; the tick is dropped for this channel.
            if (wr_sel && wr_reg == 2'd3) begin
                if (wr_data == 8'h00 || vol_init == 4'd0) begin
                    active  <= 1'b0;
                    vol_cur <= '0;
                end else begin
                    active    <= 1'b1;
                    vol_cur   <= vol_init;
                    decay_cnt <= decay_rate;
                    dur_cnt   <= wr_data;
                end
            end else if (tick && active) begin
                if (dur_cnt == 8'h01) begin
                    active  <= 1'b0;
                    vol_cur <= '0;
                end else begin
                    if (dur_cnt != 8'hFF && dur_cnt != 8'h00)
                        dur_cnt <= dur_cnt - 8'd1;
                    if (decay_rate != 4'd0) begin
                        if (decay_cnt == 4'd1) begin
                            decay_cnt <= decay_rate;
                            if (vol_cur != 4'd0) vol_cur <= vol_cur - 4'd1;
                            if (vol_cur <= 4'd1) active <= 1'b0;
                        end else if (decay_cnt != 4'd0) begin
                            decay_cnt <= decay_cnt - 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign vol = active ? vol_cur : 4'd0;
endmodule

module audio_voice_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 16667
) (
    input  logic                clk_1mhz,
    input  logic                rst,
    audio_voice_if.slave        bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]              presc;
    logic                       frame_tick;
    logic [NUM_CH-1:0][15:0]    freq_a;
    logic [NUM_CH-1:0][3:0]     vol_a;
    logic [NUM_CH-1:0]          active_a;
    logic [CW-1:0]              wr_ch;

    // frame_tick is high in the cycle right after the prescaler wrap cycle.
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            frame_tick <= 1'b0;
        end else begin
            presc      <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            frame_tick <= (presc == PRESC_LAST);
        end
    end

    assign wr_ch = bus.wr_addr[CW+1:2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        audio_voice_lane u_lane (
            .clk_1mhz (clk_1mhz),
            .rst      (rst),
            .tick     (frame_tick),
            .wr_sel   (bus.wr_en && wr_ch == CW'(i)),
            .wr_reg   (bus.wr_addr[1:0]),
            .wr_data  (bus.wr_data),
            .freq     (freq_a[i]),
            .vol      (vol_a[i]),
            .active   (active_a[i])
        );
    end

    assign bus.freq_out   = freq_a;
    assign bus.vol_out    = vol_a;
    assign bus.active     = active_a;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Scoreboard bench for audio_voice_scheduler with a short frame period.
module tb_audio_voice_scheduler;
    localparam int NUM_CH   = 4;
    localparam int TICK_DIV = 4;

    logic clk_1mhz = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_1mhz = ~clk_1mhz;

    audio_voice_if #(.NUM_CH(NUM_CH)) bus ();

    audio_voice_scheduler #(.NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV)) dut (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .bus      (bus.slave)
    );

    typedef struct {
        string tag;
        int    kind;
        int    ch;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic torn   = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 freq[ch], 1 vol[ch], 2 active[ch], 3 active vector, 4 vol vector, 5 frame_tick
    function automatic int observe(input int kind, input int ch);
        case (kind)
            0:       return int'(bus.freq_out[ch*16 +: 16]);
            1:       return int'(bus.vol_out[ch*4 +: 4]);
            2:       return int'(bus.active[ch]);
            3:       return int'(bus.active);
            4:       return int'(bus.vol_out);
            default: return int'(bus.frame_tick);
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input int ch, input int val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.ch = ch; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.kind, e.ch), e.val);
        end
    endtask

    task automatic wr_now(input int ch, input int r, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'((ch << 2) | r);
        bus.wr_data = 8'(d);
        @(negedge clk_1mhz);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wr(input int ch, input int r, input int d);
        @(negedge clk_1mhz);
        wr_now(ch, r, d);
    endtask

    task automatic wait_tick_cycle();
        int n = 0;
        while (!bus.frame_tick && n < 20) begin
            @(negedge clk_1mhz);
            n++;
        end
        if (!bus.frame_tick) chk("tick_timeout", 0, 1);
    endtask

    // Returns one cycle after the tick edge has been processed.
    task automatic tick_done();
        wait_tick_cycle();
        @(negedge clk_1mhz);
    endtask

    always @(negedge clk_1mhz)
        if (!rst && (bus.freq_out[31:16] == 16'h0034 || bus.freq_out[31:16] == 16'h1200))
            torn <= 1'b1;

    initial begin
        int n;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge clk_1mhz);
        push("rst_freq", 0, 1, 0); push("rst_vol", 4, 0, 0);
        push("rst_active", 3, 0, 0); push("rst_tick", 5, 0, 0);
        drain();
        rst = 1'b0;

        // Atomic 16-bit frequency commit
        push("t1_lo_hold", 0, 1, 16'h0000);
        wr(1, 0, 8'h34); drain();
        push("t1_hi_commit", 0, 1, 16'h1234);
        wr(1, 1, 8'h12); drain();

        // Duration expiry, no decay
        wr(0, 2, 8'hF0);
        push("t2_vol_on", 1, 0, 4'hF); push("t2_act_on", 2, 0, 1);
        wr(0, 3, 8'h03); drain();
        tick_done(); push("t2_tick1_act", 2, 0, 1); drain();
        tick_done(); push("t2_tick2_vol", 1, 0, 4'hF); drain();
        tick_done(); push("t2_tick3_act", 2, 0, 0); push("t2_tick3_vol", 1, 0, 0); drain();

        // Linear decay, sustain duration
        wr(2, 2, 8'h32);
        push("t3_vol_on", 1, 2, 3);
        wr(2, 3, 8'hFF); drain();
        begin
            int exp_vol[6] = '{3, 2, 2, 1, 1, 0};
            for (int k = 0; k < 6; k++) begin
                tick_done();
                push($sformatf("t3_tick%0d_vol", k + 1), 1, 2, exp_vol[k]);
                push($sformatf("t3_tick%0d_act", k + 1), 2, 2, (k < 5) ? 1 : 0);
                drain();
            end
        end

        // KEYON coincident with a tick on ch3, ch0 decays on the same tick
        wr(0, 2, 8'h41);
        wr(3, 2, 8'h52);
        tick_done();
        wr_now(0, 3, 8'hFF);
        wr_now(3, 3, 8'h10);
        push("t4_ch0_on", 1, 0, 4); push("t4_ch3_on", 1, 3, 5); drain();
        tick_done();
        push("t4_ch0_t1", 1, 0, 3); push("t4_ch3_t1", 1, 3, 5); drain();
        wait_tick_cycle();
        wr_now(3, 3, 8'h10);
        push("t4_ch3_retrig", 1, 3, 5); push("t4_ch0_coinc", 1, 0, 2); drain();
        tick_done();
        push("t4_ch3_t3", 1, 3, 5); push("t4_ch0_t3", 1, 0, 1); drain();
        tick_done();
        push("t4_ch3_t4", 1, 3, 4); push("t4_ch0_t4", 1, 0, 0);
        push("t4_ch0_off", 2, 0, 0); drain();

        // Key-off paths
        wr(1, 2, 8'h00);
        push("t5_vinit0_act", 2, 1, 0); push("t5_vinit0_vol", 1, 1, 0);
        wr(1, 3, 8'h05); drain();
        wr(1, 2, 8'h70);
        push("t5_on_vol", 1, 1, 7);
        wr(1, 3, 8'h05); drain();
        push("t5_off_act", 2, 1, 0); push("t5_off_vol", 1, 1, 0);
        wr(1, 3, 8'h00); drain();

        // Asynchronous reset mid-note
        for (int c = 0; c < NUM_CH; c++) begin
            wr(c, 2, 8'h80);
            wr(c, 3, 8'hFF);
        end
        push("t6_all_act", 3, 0, 4'hF); push("t6_all_vol", 4, 0, 16'h8888); drain();
        #2 rst = 1'b1;
        #1;
        push("t6_rst_act", 3, 0, 0); push("t6_rst_vol", 4, 0, 0);
        push("t6_rst_freq", 0, 1, 0); push("t6_rst_tick", 5, 0, 0); drain();
        @(negedge clk_1mhz);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk_1mhz);
            n++;
        end while (!bus.frame_tick && n < 20);
        chk("t6_first_tick", n, TICK_DIV);

        chk("t1_no_torn_freq", int'(torn), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_voice_scheduler.md
Name: audio_voice_scheduler

Overview:
Per-voice control block for a bank of NUM_CH square-wave audio channels. It holds CPU-written frequency, volume, decay and duration registers, generates a frame tick from the 1 MHz clock, and on each tick runs per-voice note duration and linear volume-decay envelopes. Its outputs drive the freq_val and volume inputs of the channel oscillators directly.

Parameters:
NUM_CH, 4, number of voices; wr_addr channel field is log2(NUM_CH) bits, NUM_CH is a power of 2 and at least 2
TICK_DIV, 16667, clk_1mhz cycles per frame tick (about 60 Hz); minimum 2

Ports:
clk_1mhz  input  1  system clock
rst  input  1  asynchronous reset, active-high
wr_en  input  1  register write strobe, one write per cycle
wr_addr  input  log2(NUM_CH)+2  {channel, reg}; reg = wr_addr[1:0]
wr_data  input  8  write data
freq_out  output  NUM_CH*16  voice n frequency word at bits [16n+15:16n]
vol_out  output  NUM_CH*4  voice n current volume at bits [4n+3:4n]
active  output  NUM_CH  voice n note sounding
frame_tick  output  1  one-cycle pulse per frame

Behaviour:
- Reset is one clock (clk_1mhz) and asynchronous active-high. On reset every register and output is 0: freq, shadow_lo, vol_init, decay_rate, vol_cur, decay_cnt, dur_cnt, active, the prescaler and frame_tick.
- All outputs are registered. A write takes effect on the clock edge where wr_en=1 and is visible on outputs the next cycle.
- Register map per channel:
  - reg 0 (FREQ_LO): wr_data goes to shadow_lo only. Output frequency is unchanged.
  - reg 1 (FREQ_HI): freq <= {wr_data, shadow_lo}. This is an atomic 16-bit commit with no half-updated word on freq_out.
  - reg 2 (ENV): vol_init <= wr_data[7:4], decay_rate <= wr_data[3:0]. It does not touch vol_cur or decay_cnt of a sounding note.
  - reg 3 (KEYON): starts or stops a note.
    - wr_data=0: key-off. active <= 0, vol_cur <= 0.
    - Otherwise, if vol_init=0: key-off as above.
    - Otherwise: active <= 1, vol_cur <= vol_init, decay_cnt <= decay_rate, dur_cnt <= wr_data.
    - Retrigger while active restarts the note identically.
- Prescaler counts 0..TICK_DIV-1 and wraps. frame_tick=1 for exactly the one cycle following the wrap cycle, i.e. the first tick appears TICK_DIV cycles after reset release.
- On a cycle where frame_tick=1, each active voice updates as follows:
  - Duration: if dur_cnt=0xFF, the note sustains and there is no countdown. Else if dur_cnt=1, expire: active <= 0, vol_cur <= 0. Else dur_cnt <= dur_cnt-1.
  - Decay, only if decay_rate != 0 and not expiring:
    - If decay_cnt=1: vol_cur <= vol_cur-1 and decay_cnt <= decay_rate.
    - Else decay_cnt <= decay_cnt-1.
    - If the decrement takes vol_cur from 1 to 0, active <= 0 on the same edge.
  - decay_rate=0 means no decay; volume holds at vol_init.
  - Inactive voices ignore ticks.
- vol_out[n] = active[n] ? vol_cur[n] : 0. freq_out always reflects the committed freq, independent of active.
- Simultaneous events:
  - A KEYON write on a tick cycle for the same channel wins; tick processing is skipped for that channel on that edge.
  - Ticks for other channels proceed normally.
  - An ENV write on a tick cycle: the tick uses the old decay_rate for its reload; the new value applies from the next cycle.
- Duration expiry takes priority over decay on the same tick.
- Arithmetic: all counters are unsigned and never wrap below 0; vol_cur saturates at 0.
- Reset asserted mid-note kills all voices asynchronously. After release, the prescaler restarts from 0.

Test Plan:
1. Reset, then write ch1 FREQ_LO=0x34 and FREQ_HI=0x12 -> freq_out[31:16] stays 0x0000 after the LO write, reads 0x1234 one cycle after the HI write, and is never 0x0034 or 0x1200.
2. TICK_DIV=4; ch0 ENV=0xF0, KEYON=0x03 -> vol_out[3:0]=0xF and active[0]=1 next cycle; after the 3rd frame_tick, active[0]=0 and vol_out[3:0]=0.
3. TICK_DIV=4; ch2 ENV=0x32, KEYON=0xFF -> vol_out 3,3,2,2,1,1,0 across successive ticks (decrements on the 2nd, 4th and 6th ticks); active[2] clears on the 6th tick; the note never expires by duration.
4. Frame_tick cycle coincident with a KEYON write to ch3 mid-decay -> ch3 reloads vol_init and the full duration; ch0 on the same tick decrements normally.
5. KEYON with vol_init=0, and separately KEYON=0x00 while sounding -> active stays or becomes 0 and vol_out=0 the next cycle.
6. Assert rst asynchronously, between clock edges, with 4 voices active -> all outputs are 0 immediately; after release, the first frame_tick comes exactly TICK_DIV cycles later.
